latency_rx_fifo: RTL and testbench

- Receive-side endpoint for a fixed-latency register pipeline. Such a pipeline moves one WIDTH-bit word per clock and has no backpressure.
- Words arriving at the pipeline tail are buffered in a DEPTH-entry FIFO and presented on a valid/ready consumer port.
- The block raises STOP to the pipeline head early enough that all words already in flight (up to LATENCY) still fit in the FIFO without loss.

---
 rtl/latency_rx_fifo.sv | 59 +++++
 tb/tb_latency_rx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/latency_rx_fifo.sv
// Receive-side FIFO for a fixed-latency, no-backpressure register pipeline.
// STOP is raised early enough to absorb every word already in flight.
module latency_rx_fifo #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_VALID,
  output logic                       STOP,
  output logic [WIDTH-1:0]           O,
  output logic                       O_VALID,
  input  logic                       O_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       OVERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             push;
  logic             pop;

  assign O_VALID  = (count != '0);
  assign O        = mem[rd_ptr];
  assign pop      = O_VALID & O_READY;
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign push     = I_VALID & ((count < CW'(DEPTH)) | pop);
  // Decoded from registered count only, so the pipeline head sees no input path.
  assign STOP     = (count >= CW'(DEPTH - LATENCY));
  assign COUNT    = count;
  assign OVERFLOW = overflow;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (I_VALID & ~push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push) mem[wr_ptr] <= I;
  end

endmodule

// File: tb/tb_latency_rx_fifo.sv
// Bench for latency_rx_fifo: directed vector table, hand sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_latency_rx_fifo;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 4;
  localparam int CW      = $clog2(DEPTH+1);

  logic             CLK = 1'b0;
  logic             RESET;
  logic [WIDTH-1:0] I;
  logic             I_VALID;
  logic             STOP;
  logic [WIDTH-1:0] O;
  logic             O_VALID;
  logic             O_READY;
  logic [CW-1:0]    COUNT;
  logic             OVERFLOW;

  int checks   = 0;
  int failures = 0;

  latency_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .I_VALID(I_VALID), .STOP(STOP),
    .O(O), .O_VALID(O_VALID), .O_READY(O_READY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] i;
    logic             rdy;
    int               cnt;
    logic             ov;
    logic [WIDTH-1:0] o;
    logic             stop;
    logic             ovf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain queue of stored words plus a sticky drop flag.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf;

  function automatic void add(logic rst, logic iv, logic [WIDTH-1:0] i, logic rdy,
                              int cnt, logic ov, logic [WIDTH-1:0] o,
                              logic stop, logic ovf);
    vec_t v;
    v.rst = rst; v.iv = iv; v.i = i; v.rdy = rdy;
    v.cnt = cnt; v.ov = ov; v.o = o; v.stop = stop; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic rst, logic iv, logic [WIDTH-1:0] i, logic rdy);
    RESET   = rst;
    I_VALID = iv;
    I       = i;
    O_READY = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, int cnt, logic ov, logic [WIDTH-1:0] o,
                           logic stop, logic ovf);
    chk({tag, " COUNT"},    int'(COUNT),    cnt);
    chk({tag, " O_VALID"},  int'(O_VALID),  int'(ov));
    if (ov) chk({tag, " O"}, int'(O),       int'(o));
    chk({tag, " STOP"},     int'(STOP),     int'(stop));
    chk({tag, " OVERFLOW"}, int'(OVERFLOW), int'(ovf));
  endtask

  function automatic void model_step(logic rst, logic iv, logic [WIDTH-1:0] i, logic rdy);
    logic do_pop;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    do_pop = (mq.size() != 0) && rdy;
    if (do_pop) void'(mq.pop_front());
    if (iv) begin
      if (mq.size() < DEPTH) mq.push_back(i);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic step_model(string tag, logic rst, logic iv, logic [WIDTH-1:0] i, logic rdy);
    int               n;
    logic [WIDTH-1:0] head;
    drive(rst, iv, i, rdy);
    model_step(rst, iv, i, rdy);
    n    = mq.size();
    head = (n != 0) ? mq[0] : '0;
    check_all(tag, n, n != 0, head, n >= DEPTH - LATENCY, m_ovf);
  endtask

  logic             pipe_v [LATENCY];
  logic [WIDTH-1:0] pipe_d [LATENCY];

  initial begin
    RESET = 1'b1; I_VALID = 1'b0; I = '0; O_READY = 1'b0;

    // reset, then idle
    add(1,0,4'h0,0, 0,0,4'h0,0,0);
    add(0,0,4'h0,0, 0,0,4'h0,0,0);
    // basic stream, consumer always ready
    add(0,1,4'h3,1, 1,1,4'h3,0,0);
    add(0,1,4'h5,1, 1,1,4'h5,0,0);
    add(0,1,4'h9,1, 1,1,4'h9,0,0);
    add(0,0,4'h0,1, 0,0,4'h0,0,0);
    // backpressure threshold: STOP at COUNT=4, in-flight words still fit
    for (int k = 1; k <= 8; k++)
      add(0,1,4'(k),0, k,1,4'h1,(k >= 4),0);
    for (int k = 7; k >= 0; k--)
      add(0,0,4'h0,1, k,(k != 0),4'(8-k+1),(k >= 4),0);
    // refill, then push on full with a simultaneous pop
    for (int k = 1; k <= 8; k++)
      add(0,1,4'(k),0, k,1,4'h1,(k >= 4),0);
    add(0,1,4'hA,1, 8,1,4'h2,1,0);
    // overflow: push on full with no pop
    add(0,1,4'hF,0, 8,1,4'h2,1,1);
    // drain: 0xF never appears, OVERFLOW sticky
    add(0,0,4'h0,1, 7,1,4'h3,1,1);
    add(0,0,4'h0,1, 6,1,4'h4,1,1);
    add(0,0,4'h0,1, 5,1,4'h5,1,1);
    add(0,0,4'h0,1, 4,1,4'h6,1,1);
    add(0,0,4'h0,1, 3,1,4'h7,0,1);
    add(0,0,4'h0,1, 2,1,4'h8,0,1);
    add(0,0,4'h0,1, 1,1,4'hA,0,1);
    add(0,0,4'h0,1, 0,0,4'h0,0,1);
    add(0,0,4'h0,0, 0,0,4'h0,0,1);
    // reset clears the sticky flag
    add(1,1,4'h6,0, 0,0,4'h0,0,0);

    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].iv, vecs[n].i, vecs[n].rdy);
      check_all($sformatf("vec%0d", n), vecs[n].cnt, vecs[n].ov, vecs[n].o,
                vecs[n].stop, vecs[n].ovf);
    end

    // wrap: 20 words 0..3 repeating, consumer ready on alternate cycles
    step_model("wrap_rst", 1, 0, 4'h0, 0);
    for (int k = 0; k < 20; k++)
      step_model($sformatf("wrap%0d", k), 0, 1, 4'(k % 4), 1'(k % 2));
    for (int k = 0; k < 24; k++)
      step_model($sformatf("wrapdrain%0d", k), 0, 0, 4'h0, 1'(k % 2));

    // mid-stream reset at COUNT=5
    step_model("mid_rst0", 1, 0, 4'h0, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, 4'(k + 1), 0);
    chk("mid COUNT before reset", int'(COUNT), 5);
    drive(1, 0, 4'h0, 0);
    chk("mid COUNT after reset", int'(COUNT), 0);
    chk("mid O_VALID after reset", int'(O_VALID), 0);
    drive(0, 1, 4'h7, 0);
    chk("mid O_VALID after push", int'(O_VALID), 1);
    chk("mid O after push", int'(O), 7);
    chk("mid COUNT after push", int'(COUNT), 1);

    // flow control: upstream obeys STOP through a LATENCY-deep pipeline
    step_model("fc_rst", 1, 0, 4'h0, 0);
    for (int s = 0; s < LATENCY; s++) begin
      pipe_v[s] = 1'b0;
      pipe_d[s] = '0;
    end
    for (int k = 0; k < 400; k++) begin
      logic             issue;
      logic [WIDTH-1:0] word;
      logic             rdy;
      logic             out_v;
      logic [WIDTH-1:0] out_d;
      issue = !STOP && ($urandom_range(3) != 0);
      word  = 4'($urandom);
      rdy   = ($urandom_range(3) == 0);
      out_v = pipe_v[LATENCY-1];
      out_d = pipe_d[LATENCY-1];
      for (int s = LATENCY-1; s > 0; s--) begin
        pipe_v[s] = pipe_v[s-1];
        pipe_d[s] = pipe_d[s-1];
      end
      pipe_v[0] = issue;
      pipe_d[0] = word;
      step_model($sformatf("fc%0d", k), 0, out_v, out_d, rdy);
    end
    chk("fc OVERFLOW never set", int'(OVERFLOW), 0);

    // unconstrained random traffic with occasional reset
    for (int k = 0; k < 400; k++)
      step_model($sformatf("rnd%0d", k), ($urandom_range(63) == 0),
                 1'($urandom), 4'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
